gray_seq_ctrl: RTL and testbench

//   Sequencer that configures and runs a WIDTH-bit up/down binary/Gray counter datapath.

---
 rtl/gray_seq_ctrl_pkg.sv | 22 ++
 rtl/gray_seq_ctrl_core.sv | 47 ++++
 rtl/gray_seq_ctrl.sv | 174 +++++++++++++++++
 tb/tb_gray_seq_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/gray_seq_ctrl_pkg.sv
// Shared types and helpers for the Gray counter sequencer: FSM states,
// mode/direction encodings and the binary-to-Gray conversion.
package gray_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_RUN   = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_WRAP    = 1'b1;
    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DN       = 1'b1;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_seq_ctrl_core.sv
// Binary counter with a companion Gray register; both update on the same edge
// from the same next value, so they can never disagree.
module gray_count_core
    import gray_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step,
    input  logic             dir,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] g_out
);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_gray;

    always_comb begin
        w_next = r_bin;
        if (load) begin
            w_next = load_val;
        end else if (step) begin
            w_next = (dir == DIR_DN) ? r_bin - WIDTH'(1) : r_bin + WIDTH'(1);
        end
    end

    assign w_gray = WIDTH'(bin2gray(32'(w_next)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bin  <= '0;
            r_gray <= '0;
        end else if (load || step) begin
            r_bin  <= w_next;
            r_gray <= w_gray;
        end
    end

    assign b_out = r_bin;
    assign g_out = r_gray;

endmodule

// File: rtl/gray_seq_ctrl.sv
// Sequencer FSM: config handshake, run/pause/abort control, terminal compare
// and done/wrap pulses around a binary/Gray counter core.
module gray_seq_ctrl
    import gray_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_start,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic             cfg_dir,
    input  logic             cfg_mode,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] g_out
);

    state_t           r_state;
    logic [WIDTH-1:0] r_start;
    logic [WIDTH-1:0] r_limit;
    logic             r_dir;
    logic             r_mode;
    logic             r_cfg_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_wrap;

    logic             w_cfg_acc;
    logic             w_go;
    logic             w_at_limit;
    logic             w_load;
    logic             w_step;
    logic [WIDTH-1:0] w_load_val;

    assign w_cfg_acc  = cfg_valid & r_cfg_ready;
    assign w_go       = start & ~stop;
    assign w_at_limit = (b_out == r_limit);

    // Counter commands are decoded from the current state so the count moves on the same edge as the FSM.
    always_comb begin
        w_load     = 1'b0;
        w_step     = 1'b0;
        w_load_val = r_start;
        case (r_state)
            ST_IDLE: begin
                if (w_cfg_acc) begin
                    w_load     = 1'b1;
                    w_load_val = cfg_start;
                end
            end
            ST_DONE: begin
                if (w_cfg_acc) begin
                    w_load     = 1'b1;
                    w_load_val = cfg_start;
                end else if (w_go) begin
                    w_load = 1'b1;
                end
            end
            ST_RUN: begin
                if (!stop) begin
                    if (!w_at_limit)
                        w_step = 1'b1;
                    else if (r_mode == MODE_WRAP)
                        w_load = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_start <= '0;
            r_limit <= '0;
            r_dir   <= DIR_UP;
            r_mode  <= MODE_ONESHOT;
        end else if (w_cfg_acc) begin
            r_start <= cfg_start;
            r_limit <= cfg_limit;
            r_dir   <= cfg_dir;
            r_mode  <= cfg_mode;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_wrap <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_cfg_acc) begin
                        r_state     <= ST_ARMED;
                        r_cfg_ready <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (stop) begin
                        r_state     <= ST_IDLE;
                        r_cfg_ready <= 1'b1;
                    end else if (start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        r_state <= ST_HOLD;
                    end else if (w_at_limit && r_mode == MODE_ONESHOT) begin
                        r_state     <= ST_DONE;
                        r_busy      <= 1'b0;
                        r_cfg_ready <= 1'b1;
                        r_done      <= 1'b1;
                    end else if (w_at_limit) begin
                        r_wrap <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (stop) begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_cfg_ready <= 1'b1;
                    end else if (start) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (w_cfg_acc) begin
                        r_state     <= ST_ARMED;
                        r_cfg_ready <= 1'b0;
                    end else if (w_go) begin
                        r_state     <= ST_RUN;
                        r_busy      <= 1'b1;
                        r_cfg_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_cfg_ready <= 1'b1;
                end
            endcase
        end
    end

    gray_count_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .step     (w_step),
        .dir      (r_dir),
        .b_out    (b_out),
        .g_out    (g_out)
    );

    assign cfg_ready = r_cfg_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign wrap      = r_wrap;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Directed bench for gray_seq_ctrl with a behavioural reference model and
// literal spot checks of the counting sequences.
module tb_gray_seq_ctrl;

    localparam int W   = 4;
    localparam int MOD = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [W-1:0] cfg_start = '0;
    logic [W-1:0] cfg_limit = '0;
    logic         cfg_dir = 1'b0;
    logic         cfg_mode = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         busy, done, wrap;
    logic [W-1:0] b_out, g_out;

    int n_checks = 0;
    int n_fail   = 0;

    gray_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_start (cfg_start),
        .cfg_limit (cfg_limit),
        .cfg_dir   (cfg_dir),
        .cfg_mode  (cfg_mode),
        .start     (start),
        .stop      (stop),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap),
        .b_out     (b_out),
        .g_out     (g_out)
    );

    always #5 clk = ~clk;

    // Reference model: phase name plus an integer count advanced modulo MOD
    string m_ph   = "IDLE";
    int    m_cnt  = 0;
    int    m_s    = 0;
    int    m_l    = 0;
    int    m_d    = 0;
    int    m_m    = 0;
    int    m_done = 0;
    int    m_wrap = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ph = "IDLE"; m_cnt = 0; m_s = 0; m_l = 0; m_d = 0; m_m = 0;
            m_done = 0; m_wrap = 0;
        end else begin
            m_done = 0;
            m_wrap = 0;
            if ((m_ph == "IDLE" || m_ph == "DONE") && cfg_valid) begin
                m_s = cfg_start; m_l = cfg_limit; m_d = cfg_dir; m_m = cfg_mode;
                m_cnt = m_s;
                m_ph = "ARMED";
            end else if (m_ph == "ARMED") begin
                if (stop) m_ph = "IDLE";
                else if (start) m_ph = "RUN";
            end else if (m_ph == "RUN") begin
                if (stop) m_ph = "HOLD";
                else if (m_cnt == m_l) begin
                    if (m_m == 0) begin m_ph = "DONE"; m_done = 1; end
                    else begin m_cnt = m_s; m_wrap = 1; end
                end else begin
                    m_cnt = (m_cnt + (m_d != 0 ? MOD - 1 : 1)) % MOD;
                end
            end else if (m_ph == "HOLD") begin
                if (stop) m_ph = "IDLE";
                else if (start) m_ph = "RUN";
            end else if (m_ph == "DONE") begin
                if (start && !stop) begin m_cnt = m_s; m_ph = "RUN"; end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("model_b",     int'(b_out),     m_cnt);
        check("model_g",     int'(g_out),     m_cnt ^ (m_cnt / 2));
        check("model_busy",  int'(busy),      (m_ph == "RUN" || m_ph == "HOLD") ? 1 : 0);
        check("model_ready", int'(cfg_ready), (m_ph == "IDLE" || m_ph == "DONE") ? 1 : 0);
        check("model_done",  int'(done),      m_done);
        check("model_wrap",  int'(wrap),      m_wrap);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_cfg(input int s, input int l, input int d, input int m);
        cfg_valid = 1'b1;
        cfg_start = W'(s);
        cfg_limit = W'(l);
        cfg_dir   = d[0];
        cfg_mode  = m[0];
        tick();
        cfg_valid = 1'b0;
    endtask

    int exp_b1 [5] = '{3, 4, 5, 6, 7};
    int exp_g1 [5] = '{2, 6, 7, 5, 4};
    int exp_b2 [8] = '{0, 15, 14, 1, 0, 15, 14, 1};
    int exp_g2 [8] = '{0, 8, 9, 1, 0, 8, 9, 1};
    int exp_w2 [8] = '{0, 0, 0, 1, 0, 0, 0, 1};

    initial begin
        #12;
        check("rst_ready", int'(cfg_ready), 1);
        check("rst_b",     int'(b_out), 0);
        check("rst_busy",  int'(busy), 0);
        rst = 1'b1;
        tick();

        // 1: one-shot up 3..7
        do_cfg(3, 7, 0, 0);
        check("t1_load_b", int'(b_out), 3);
        start = 1'b1; tick(); start = 1'b0;
        check("t1_run_busy", int'(busy), 1);
        check("t1_run_b", int'(b_out), exp_b1[0]);
        for (int i = 1; i < 5; i++) begin
            tick();
            check("t1_b", int'(b_out), exp_b1[i]);
            check("t1_g", int'(g_out), exp_g1[i]);
            check("t1_nodone", int'(done), 0);
        end
        tick();
        check("t1_done", int'(done), 1);
        check("t1_busy", int'(busy), 0);
        check("t1_hold_b", int'(b_out), 7);
        tick();
        check("t1_done_pulse", int'(done), 0);

        // 2: wrap mode counting down across zero
        do_cfg(1, 14, 1, 1);
        check("t2_load_b", int'(b_out), 1);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t2_b", int'(b_out), exp_b2[i]);
            check("t2_g", int'(g_out), exp_g2[i]);
            check("t2_wrap", int'(wrap), exp_w2[i]);
        end
        stop = 1'b1; tick(); tick(); stop = 1'b0;
        check("t2_idle_ready", int'(cfg_ready), 1);

        // 3: pause and resume
        do_cfg(2, 12, 0, 0);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 3; i <= 5; i++) begin
            tick();
            check("t3_b", int'(b_out), i);
        end
        stop = 1'b1; tick(); stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_hold_b", int'(b_out), 5);
            check("t3_hold_busy", int'(busy), 1);
        end
        start = 1'b1; tick(); start = 1'b0;
        check("t3_resume_b", int'(b_out), 5);
        tick();
        check("t3_step_b", int'(b_out), 6);
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        tick();
        check("t3_both_b", int'(b_out), 6);
        check("t3_both_busy", int'(busy), 1);

        // 4: abort and reconfigure
        stop = 1'b1; tick(); stop = 1'b0;
        check("t4_busy", int'(busy), 0);
        check("t4_ready", int'(cfg_ready), 1);
        check("t4_keep_b", int'(b_out), 6);
        do_cfg(9, 11, 0, 0);
        check("t4_b", int'(b_out), 9);
        check("t4_g", int'(g_out), 13);
        cfg_valid = 1'b1; cfg_start = 4'd2; tick(); cfg_valid = 1'b0;
        check("t4_armed_ignore", int'(b_out), 9);
        stop = 1'b1; tick(); stop = 1'b0;
        check("t4_armed_abort", int'(cfg_ready), 1);

        // 5: start == limit, then restart from DONE
        do_cfg(4, 4, 0, 0);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        check("t5_done", int'(done), 1);
        check("t5_b", int'(b_out), 4);
        tick();
        start = 1'b1; tick(); start = 1'b0;
        check("t5_restart_busy", int'(busy), 1);
        tick();
        check("t5_done2", int'(done), 1);

        // 6: asynchronous reset mid-run
        do_cfg(3, 10, 0, 0);
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        check("t6_pre_b", int'(b_out), 6);
        #1 rst = 1'b0;
        #1;
        check("t6_rst_b", int'(b_out), 0);
        check("t6_rst_g", int'(g_out), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_done", int'(done), 0);
        tick(); tick();
        rst = 1'b1;
        tick();
        check("t6_ready", int'(cfg_ready), 1);
        check("t6_nodone", int'(done), 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
